mc_control_unit: RTL

Multi-cycle control unit for the single-memory MIPS-subset datapath. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath strobes and mux selects, including the 3-bit ALU B-operand select (ULAb), the ALU A select and the ALU operation code. It sits beside the datapath top level, taking only the instruction fields and the ALU zero flag as inputs.

---
 rtl/mc_control_unit_if.sv | 38 +++
 rtl/mc_control_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit_if.sv
// Control/datapath boundary for the multi-cycle MIPS-subset core.
// The control unit takes the master view; the datapath (or a bench) takes the slave view.
interface mc_control_unit_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       PCwrite;
   logic [1:0] PCsrc;
   logic       IorD;
   logic       MemWrite;
   logic       IRwrite;
   logic       ABwrite;
   logic       ALUOutWrite;
   logic       MDRwrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemToReg;
   logic       ULAa;
   logic [2:0] ULAb;
   logic [2:0] ULAop;
   logic       instr_done;
   logic       illegal;
   logic [4:0] state_out;

   modport master (
      input  opcode, funct, zero,
      output PCwrite, PCsrc, IorD, MemWrite, IRwrite, ABwrite, ALUOutWrite,
             MDRwrite, RegWrite, RegDst, MemToReg, ULAa, ULAb, ULAop,
             instr_done, illegal, state_out
   );

   modport slave (
      output opcode, funct, zero,
      input  PCwrite, PCsrc, IorD, MemWrite, IRwrite, ABwrite, ALUOutWrite,
             MDRwrite, RegWrite, RegDst, MemToReg, ULAa, ULAb, ULAop,
             instr_done, illegal, state_out
   );
endinterface

// File: rtl/mc_control_unit.sv
// Moore FSM sequencing fetch/decode/execute/memory/write-back for the multi-cycle datapath.
// Strobes are registered decodes of the next state; only the branch PC write looks at zero live.
module mc_control_unit #(
   parameter int MEM_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   mc_control_unit_if.master bus
);
   typedef enum logic [4:0] {
      S_RESET       = 5'd0,
      S_FETCH       = 5'd1,
      S_FETCH_WAIT  = 5'd2,
      S_FETCH_LOAD  = 5'd3,
      S_DECODE      = 5'd4,
      S_EXEC_R      = 5'd5,
      S_WB_R        = 5'd6,
      S_EXEC_ADDI   = 5'd7,
      S_WB_I        = 5'd8,
      S_MEM_ADDR    = 5'd9,
      S_MEM_RD      = 5'd10,
      S_MEM_RD_WAIT = 5'd11,
      S_WB_MEM      = 5'd12,
      S_MEM_WR      = 5'd13,
      S_BRANCH      = 5'd14,
      S_JUMP        = 5'd15,
      S_HALT        = 5'd16
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       ab_write;
      logic       aluout_write;
      logic       mdr_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       ula_a;
      logic [2:0] ula_b;
      logic [2:0] ula_op;
      logic       instr_done;
   } ctl_t;

   localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
   localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
   localparam logic [2:0] B_REG = 3'b000, B_IMM = 3'b001, B_FOUR = 3'b010, B_IMM_SH2 = 3'b100;

   state_t     st, nxt;
   logic [1:0] cnt, cnt_nxt;
   ctl_t       ctl;
   logic       illegal_q;
   logic       bne_q;

   function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE:      dispatch = (fn == FN_ADD || fn == FN_SUB || fn == FN_AND) ? S_EXEC_R : S_HALT;
         OP_ADDI:       dispatch = S_EXEC_ADDI;
         OP_LW, OP_SW:  dispatch = S_MEM_ADDR;
         OP_BEQ, OP_BNE: dispatch = S_BRANCH;
         OP_J:          dispatch = S_JUMP;
         default:       dispatch = S_HALT;
      endcase
   endfunction

   function automatic ctl_t decode(input state_t s, input logic [1:0] c, input logic [5:0] fn);
      ctl_t o;
      o = '0;
      case (s)
         S_FETCH:      begin o.ula_b = B_FOUR; o.ula_op = ALU_ADD; o.pc_write = 1'b1; end
         S_FETCH_LOAD: o.ir_write = 1'b1;
         S_DECODE: begin
            o.ab_write = 1'b1; o.ula_b = B_IMM_SH2; o.ula_op = ALU_ADD; o.aluout_write = 1'b1;
         end
         S_EXEC_R: begin
            o.ula_a = 1'b1; o.ula_b = B_REG; o.aluout_write = 1'b1;
            case (fn)
               FN_SUB:  o.ula_op = ALU_SUB;
               FN_AND:  o.ula_op = ALU_AND;
               default: o.ula_op = ALU_ADD;
            endcase
         end
         S_WB_R:       begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1; end
         S_EXEC_ADDI, S_MEM_ADDR: begin
            o.ula_a = 1'b1; o.ula_b = B_IMM; o.ula_op = ALU_ADD; o.aluout_write = 1'b1;
         end
         S_WB_I:        begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
         S_MEM_RD:      o.iord = 1'b1;
         S_MEM_RD_WAIT: begin o.iord = 1'b1; o.mdr_write = (c == WAIT_LAST); end
         S_WB_MEM:      begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; end
         S_MEM_WR:      begin o.iord = 1'b1; o.mem_write = 1'b1; o.instr_done = 1'b1; end
         // PC write for branches is added outside, from the live zero flag
         S_BRANCH: begin
            o.ula_a = 1'b1; o.ula_b = B_REG; o.ula_op = ALU_SUB; o.pc_src = 2'b01; o.instr_done = 1'b1;
         end
         S_JUMP:        begin o.pc_src = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1; end
         default:       o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      nxt     = st;
      cnt_nxt = '0;
      case (st)
         S_RESET:      nxt = S_FETCH;
         S_FETCH:      nxt = S_FETCH_WAIT;
         S_FETCH_WAIT: if (cnt == WAIT_LAST) nxt = S_FETCH_LOAD; else cnt_nxt = cnt + 2'd1;
         S_FETCH_LOAD: nxt = S_DECODE;
         S_DECODE:     nxt = dispatch(bus.opcode, bus.funct);
         S_EXEC_R:     nxt = S_WB_R;
         S_EXEC_ADDI:  nxt = S_WB_I;
         S_MEM_ADDR:   nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:     nxt = S_MEM_RD_WAIT;
         S_MEM_RD_WAIT: if (cnt == WAIT_LAST) nxt = S_WB_MEM; else cnt_nxt = cnt + 2'd1;
         S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: nxt = S_FETCH;
         S_HALT:       nxt = S_HALT;
         default:      nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= S_RESET;
         cnt       <= '0;
         ctl       <= '0;
         illegal_q <= 1'b0;
         bne_q     <= 1'b0;
      end else begin
         st  <= nxt;
         cnt <= cnt_nxt;
         ctl <= decode(nxt, cnt_nxt, bus.funct);
         if (nxt == S_HALT) illegal_q <= 1'b1;
         if (st == S_DECODE) bne_q <= (bus.opcode == OP_BNE);
      end
   end

   assign bus.PCwrite     = ctl.pc_write | ((st == S_BRANCH) & (bus.zero ^ bne_q));
   assign bus.PCsrc       = ctl.pc_src;
   assign bus.IorD        = ctl.iord;
   assign bus.MemWrite    = ctl.mem_write;
   assign bus.IRwrite     = ctl.ir_write;
   assign bus.ABwrite     = ctl.ab_write;
   assign bus.ALUOutWrite = ctl.aluout_write;
   assign bus.MDRwrite    = ctl.mdr_write;
   assign bus.RegWrite    = ctl.reg_write;
   assign bus.RegDst      = ctl.reg_dst;
   assign bus.MemToReg    = ctl.mem_to_reg;
   assign bus.ULAa        = ctl.ula_a;
   assign bus.ULAb        = ctl.ula_b;
   assign bus.ULAop       = ctl.ula_op;
   assign bus.instr_done  = ctl.instr_done;
   assign bus.illegal     = illegal_q;
   assign bus.state_out   = st;
endmodule
